// File: rtl/vga_pattern_gen.sv
// VGA timing generator with four test patterns: vertical bars, horizontal bars,
// checkerboard and a solid colour. All outputs are registered one clock behind the counters.
module vga_pattern_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int COLOR_W    = 4,
  parameter int BARS       = 3,
  parameter int CHECK_LOG2 = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             mode,
  input  logic [3*COLOR_W-1:0]   solid_rgb,
  output logic                   vga_h_sync,
  output logic                   vga_v_sync,
  output logic [COLOR_W-1:0]     vga_R,
  output logic [COLOR_W-1:0]     vga_G,
  output logic [COLOR_W-1:0]     vga_B,
  output logic                   in_display_area,
  output logic                   frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int A_MAX   = (H_ACTIVE > V_ACTIVE) ? H_ACTIVE : V_ACTIVE;
  localparam int AW      = $clog2(2 * A_MAX + 1);
  localparam int RGB_W   = 3 * COLOR_W;

  localparam logic [COLOR_W-1:0] C_MAX  = {COLOR_W{1'b1}};
  localparam logic [COLOR_W-1:0] C_ZERO = '0;

  logic [HW-1:0]      h_cnt_reg;
  logic [VW-1:0]      v_cnt_reg;
  logic [1:0]         mode_reg;
  logic [RGB_W-1:0]   solid_reg;
  logic [RGB_W-1:0]   rgb_reg;
  logic               h_sync_reg;
  logic               v_sync_reg;
  logic               de_reg;
  logic               fs_reg;

  logic               h_last;
  logic               v_last;
  logic               visible;
  logic [RGB_W-1:0]   rgb_next;
  logic [1:0]         step_en;
  logic [1:0]         reload_en;
  logic [1:0]         bar_idx [2];

  function automatic logic [RGB_W-1:0] palette(input logic [1:0] idx);
    case (idx)
      2'd0:    palette = {C_ZERO, C_ZERO, C_MAX};
      2'd1:    palette = {C_MAX,  C_MAX,  C_MAX};
      2'd2:    palette = {C_MAX,  C_ZERO, C_ZERO};
      default: palette = {C_ZERO, C_MAX,  C_ZERO};
    endcase
  endfunction

  assign h_last  = (int'(h_cnt_reg) == H_TOTAL - 1);
  assign v_last  = (int'(v_cnt_reg) == V_TOTAL - 1);
  assign visible = (int'(h_cnt_reg) < H_ACTIVE) && (int'(v_cnt_reg) < V_ACTIVE);

  assign step_en   = {h_last, 1'b1};
  assign reload_en = {h_last && v_last, h_last};

  // Bar index per axis tracked incrementally: bar(x) = floor(((x+1)*BARS-1)/ACTIVE),
  // with the remainder kept in acc_reg so no divider is needed. Only index mod 4 matters.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_axis
      localparam int AX     = (gi == 0) ? H_ACTIVE : V_ACTIVE;
      localparam int STEP_Q = BARS / AX;
      localparam int STEP_R = BARS % AX;
      localparam int INIT_Q = (BARS - 1) / AX;
      localparam int INIT_R = (BARS - 1) % AX;

      logic [AW-1:0] acc_reg;
      logic [1:0]    bar_reg;
      logic [AW-1:0] acc_sum;
      logic          acc_carry;
      logic [AW-1:0] acc_next;
      logic [1:0]    bar_next;

      always_comb begin
        acc_sum   = acc_reg + AW'(STEP_R);
        acc_carry = (acc_sum >= AW'(AX));
        acc_next  = acc_carry ? (acc_sum - AW'(AX)) : acc_sum;
        bar_next  = bar_reg + 2'(STEP_Q % 4) + {1'b0, acc_carry};
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          acc_reg <= AW'(INIT_R);
          bar_reg <= 2'(INIT_Q % 4);
        end else if (reload_en[gi]) begin
          acc_reg <= AW'(INIT_R);
          bar_reg <= 2'(INIT_Q % 4);
        end else if (step_en[gi]) begin
          acc_reg <= acc_next;
          bar_reg <= bar_next;
        end
      end

      assign bar_idx[gi] = bar_reg;
    end
  endgenerate

  always_comb begin
    rgb_next = '0;
    if (visible) begin
      case (mode_reg)
        2'd0:    rgb_next = palette(bar_idx[0]);
        2'd1:    rgb_next = palette(bar_idx[1]);
        2'd2:    rgb_next = (h_cnt_reg[CHECK_LOG2] ^ v_cnt_reg[CHECK_LOG2]) ? {RGB_W{1'b1}} : '0;
        default: rgb_next = solid_reg;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt_reg  <= '0;
      v_cnt_reg  <= '0;
      mode_reg   <= 2'd0;
      solid_reg  <= '0;
      rgb_reg    <= '0;
      h_sync_reg <= 1'b1;
      v_sync_reg <= 1'b1;
      de_reg     <= 1'b0;
      fs_reg     <= 1'b0;
    end else begin
      if (h_last) begin
        h_cnt_reg <= '0;
        v_cnt_reg <= v_last ? '0 : v_cnt_reg + VW'(1);
      end else begin
        h_cnt_reg <= h_cnt_reg + HW'(1);
      end
      // Pattern controls only change on the very last pixel so a frame is never torn.
      if (h_last && v_last) begin
        mode_reg  <= mode;
        solid_reg <= solid_rgb;
      end
      rgb_reg    <= rgb_next;
      h_sync_reg <= !((int'(h_cnt_reg) >= H_ACTIVE + H_FP) &&
                      (int'(h_cnt_reg) <  H_ACTIVE + H_FP + H_SYNC));
      v_sync_reg <= !((int'(v_cnt_reg) >= V_ACTIVE + V_FP) &&
                      (int'(v_cnt_reg) <  V_ACTIVE + V_FP + V_SYNC));
      de_reg     <= visible;
      fs_reg     <= (h_cnt_reg == '0) && (v_cnt_reg == '0);
    end
  end

  logic [COLOR_W-1:0] chan [3];

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_chan
      assign chan[gi] = rgb_reg[(2 - gi) * COLOR_W +: COLOR_W];
    end
  endgenerate

  assign vga_R           = chan[0];
  assign vga_G           = chan[1];
  assign vga_B           = chan[2];
  assign vga_h_sync      = h_sync_reg;
  assign vga_v_sync      = v_sync_reg;
  assign in_display_area = de_reg;
  assign frame_start     = fs_reg;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Scoreboard bench: three generators (BARS=3/1/4) on a reduced 80x50 raster, every output
// pixel compared against an independent model of the pattern rules.
module tb_vga_pattern_gen;

  localparam int HA = 64, HF = 4, HS = 8, HB = 4;
  localparam int VA = 40, VF = 2, VS = 3, VB = 5;
  localparam int CL = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam logic [15:0] RST_OBS = 16'hC000;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  mode;
  logic [11:0] solid_rgb;

  logic       hs_a, vs_a, de_a, fs_a;
  logic [3:0] r_a, g_a, b_a;
  logic       hs_b, vs_b, de_b, fs_b;
  logic [3:0] r_b, g_b, b_b;
  logic       hs_c, vs_c, de_c, fs_c;
  logic [3:0] r_c, g_c, b_c;

  always #5 clk = ~clk;

  vga_pattern_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
                    .COLOR_W(4), .BARS(3), .CHECK_LOG2(CL)) dut_a (
    .clk(clk), .reset(reset), .mode(mode), .solid_rgb(solid_rgb),
    .vga_h_sync(hs_a), .vga_v_sync(vs_a), .vga_R(r_a), .vga_G(g_a), .vga_B(b_a),
    .in_display_area(de_a), .frame_start(fs_a));

  vga_pattern_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
                    .COLOR_W(4), .BARS(1), .CHECK_LOG2(CL)) dut_b (
    .clk(clk), .reset(reset), .mode(mode), .solid_rgb(solid_rgb),
    .vga_h_sync(hs_b), .vga_v_sync(vs_b), .vga_R(r_b), .vga_G(g_b), .vga_B(b_b),
    .in_display_area(de_b), .frame_start(fs_b));

  vga_pattern_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
                    .COLOR_W(4), .BARS(4), .CHECK_LOG2(CL)) dut_c (
    .clk(clk), .reset(reset), .mode(mode), .solid_rgb(solid_rgb),
    .vga_h_sync(hs_c), .vga_v_sync(vs_c), .vga_R(r_c), .vga_G(g_c), .vga_B(b_c),
    .in_display_area(de_c), .frame_start(fs_c));

  logic [15:0] obs_a, obs_b, obs_c;
  assign obs_a = {hs_a, vs_a, de_a, fs_a, r_a, g_a, b_a};
  assign obs_b = {hs_b, vs_b, de_b, fs_b, r_b, g_b, b_b};
  assign obs_c = {hs_c, vs_c, de_c, fs_c, r_c, g_c, b_c};

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int bar_of(input int x, input int a, input int b);
    int r;
    r = 0;
    for (int k = 0; k < b; k++)
      if (x >= (k * a) / b && x < ((k + 1) * a) / b) r = k;
    return r;
  endfunction

  function automatic logic [11:0] pal(input int k);
    case (k % 4)
      0:       pal = 12'h00F;
      1:       pal = 12'hFFF;
      2:       pal = 12'hF00;
      default: pal = 12'h0F0;
    endcase
  endfunction

  function automatic logic [15:0] model_px(input int h, input int v, input logic [1:0] m,
                                           input logic [11:0] s, input int bars);
    logic vis, hsy, vsy, fst;
    logic [11:0] rgb;
    vis = (h < HA) && (v < VA);
    hsy = !((h >= HA + HF) && (h < HA + HF + HS));
    vsy = !((v >= VA + VF) && (v < VA + VF + VS));
    fst = (h == 0) && (v == 0);
    rgb = 12'h000;
    if (vis) begin
      case (m)
        2'd0:    rgb = pal(bar_of(h, HA, bars));
        2'd1:    rgb = pal(bar_of(v, VA, bars));
        2'd2:    rgb = ((((h >> CL) ^ (v >> CL)) & 1) == 1) ? 12'hFFF : 12'h000;
        default: rgb = s;
      endcase
    end
    return {hsy, vsy, vis, fst, rgb};
  endfunction

  // Reference raster: one expected pixel per clock, pushed as the edge that produces it occurs.
  logic [47:0] sb_q[$];
  int          mh, mv;
  logic [1:0]  m_mode;
  logic [11:0] m_solid;
  int          n_popped = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      sb_q.delete();
      mh = 0; mv = 0; m_mode = 2'd0; m_solid = 12'h000;
    end else begin
      sb_q.push_back({model_px(mh, mv, m_mode, m_solid, 3),
                      model_px(mh, mv, m_mode, m_solid, 1),
                      model_px(mh, mv, m_mode, m_solid, 4)});
      if (mh == HT - 1 && mv == VT - 1) begin
        m_mode  = mode;
        m_solid = solid_rgb;
      end
      if (mh == HT - 1) begin
        mh = 0;
        mv = (mv == VT - 1) ? 0 : mv + 1;
      end else begin
        mh = mh + 1;
      end
    end
  end

  logic [47:0] exp_w;
  int cyc = 0, last_fs = 0, n_period = 0, hs_low = 0;
  bit fs_valid = 0;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      fs_valid = 0;
      hs_low   = 0;
    end else begin
      if (sb_q.size() > 0) begin
        exp_w = sb_q.pop_front();
        n_popped++;
        check_eq("px_bars3", obs_a, exp_w[47:32]);
        check_eq("px_bars1", obs_b, exp_w[31:16]);
        check_eq("px_bars4", obs_c, exp_w[15:0]);
      end
      if (fs_a) begin
        if (fs_valid) begin
          check_eq("fs_period", cyc - last_fs, FT);
          n_period++;
        end
        fs_valid = 1;
        last_fs  = cyc;
      end
      if (!hs_a) hs_low++;
      else if (hs_low > 0) begin
        check_eq("hsync_width", hs_low, HS);
        hs_low = 0;
      end
    end
  end

  initial begin
    mode = 2'd0;
    solid_rgb = 12'h000;
    reset = 1'b0;
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_a", obs_a, RST_OBS);
    check_eq("rst_b", obs_b, RST_OBS);
    check_eq("rst_c", obs_c, RST_OBS);
    @(negedge clk) reset = 1'b0;
    @(posedge clk) #1 check_eq("fs_first", fs_a, 1'b1);
    @(posedge clk) #1 check_eq("fs_second", fs_a, 1'b0);

    // Controls change mid-frame; the scoreboard expects them one frame later.
    repeat (FT + 10 * HT) @(negedge clk);
    mode = 2'd2;
    repeat (FT) @(negedge clk);
    mode = 2'd3;
    solid_rgb = 12'h5A3;
    repeat (FT) @(negedge clk);
    mode = 2'd1;
    repeat (FT + 20 * HT + 30) @(negedge clk);

    // Asynchronous reset in the middle of a visible line.
    #2 reset = 1'b1;
    #1;
    check_eq("rst_mid_a", obs_a, RST_OBS);
    check_eq("rst_mid_b", obs_b, RST_OBS);
    check_eq("rst_mid_c", obs_c, RST_OBS);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(posedge clk) #1 check_eq("fs_after_rst", fs_a, 1'b1);
    repeat (FT + 200) @(negedge clk);

    check_eq("fs_periods_seen", (n_period >= 4), 1'b1);
    check_eq("sb_ran", (n_popped > 5 * FT), 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vga_pattern_gen.md
VGA_PATTERN_GEN -- requirements
Module: vga_pattern_gen

Interface
REQ-001 The block SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 The block SHALL have parameters H_FP 16, H_SYNC 96, H_BP 48: horizontal front porch, sync and back porch widths in clocks.
REQ-003 The block SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-004 The block SHALL have parameters V_FP 10, V_SYNC 2, V_BP 33: vertical porch and sync widths in lines.
REQ-005 The block SHALL have parameter COLOR_W, default 4, bits per colour channel.
REQ-006 The block SHALL have parameter BARS, default 3, range 1..H_ACTIVE: number of bars in bar modes.
REQ-007 The block SHALL have parameter CHECK_LOG2, default 5: checker square side = 2^CHECK_LOG2 pixels.
REQ-008 Ports: clk  in  1  pixel clock, the only clock.
REQ-009 Ports: reset  in  1  asynchronous, active-high reset.
REQ-010 Ports: mode  in  2  pattern select (0 vertical bars, 1 horizontal bars, 2 checkerboard, 3 solid).
REQ-011 Ports: solid_rgb  in  3*COLOR_W  {R,G,B} colour for mode 3.
REQ-012 Ports: vga_h_sync, vga_v_sync  out  1 each  active-low syncs.
REQ-013 Ports: vga_R, vga_G, vga_B  out  COLOR_W each  pixel colour.
REQ-014 Ports: in_display_area  out  1  high while the output pixel is visible.
REQ-015 Ports: frame_start  out  1  one-clock pulse on the first visible pixel of each frame.

Function
REQ-016 h_cnt SHALL count 0..H_TOTAL-1 (H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP) and wrap to 0; v_cnt SHALL advance once per wrap, 0..V_TOTAL-1, then wrap to 0.
REQ-017 Counter widths SHALL be clog2 of the totals; no wrap to any value other than 0.
REQ-018 Visible region: h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
REQ-019 Sync low for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); likewise for v_cnt with vertical parameters.
REQ-020 All outputs SHALL be registered: outputs in cycle t+1 reflect counters in cycle t (latency 1); syncs, colour, in_display_area and frame_start stay mutually aligned.
REQ-021 Outside the visible region RGB SHALL be all zeros.
REQ-022 mode and solid_rgb SHALL be latched only when h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1; mid-frame changes take effect at the next frame, never tearing a frame.
REQ-023 Palette, index mod 4: 0 blue {0,0,max}, 1 white {max,max,max}, 2 red {max,0,0}, 3 green {0,max,0}; max = all ones.
REQ-024 Mode 0: bar k covers h in [floor(k*H_ACTIVE/BARS), floor((k+1)*H_ACTIVE/BARS)); colour = palette(k).
REQ-025 Mode 1: same rule as mode 0 using v_cnt and V_ACTIVE.
REQ-026 Mode 2: white if h_cnt[CHECK_LOG2] XOR v_cnt[CHECK_LOG2] is 1, else black.
REQ-027 Mode 3: latched solid_rgb on every visible pixel.
REQ-028 frame_start SHALL be high exactly one clock per frame, aligned with output pixel (0,0).

Reset
REQ-029 While reset is high: h_cnt=v_cnt=0, latched mode=0, latched solid_rgb=0, RGB=0, syncs=1, in_display_area=0, frame_start=0, asynchronously.
REQ-030 After reset deasserts, the first clock edge starts pixel (0,0) of a new frame with mode 0 active; output pixel (0,0) appears one clock later with frame_start=1.
REQ-031 Reset asserted mid-frame SHALL abort the frame immediately; no partial-line continuation.

Verification
REQ-032 Defaults, mode 0: reset, run one frame -> pixels 0..212 blue, 213..425 white, 426..639 red; H_TOTAL=800, V_TOTAL=525 measured.
REQ-033 Sync timing: measure -> h_sync low exactly 96 clocks starting 656 clocks after line start; v_sync low exactly 2 lines starting at line 490.
REQ-034 Mode change mid-frame: set mode=2 at line 100 -> current frame remains bars; next frame checkerboard, pixel (32,0) white, (32,32) black.
REQ-035 Mode 3, solid_rgb=12'h5A3 -> every visible pixel 5/A/3, blanking pixels 0; frame_start exactly one pulse per 420000 clocks.
REQ-036 Reset at line 300 pixel 400 -> outputs take reset values at once; after release, frame_start appears 1 clock after the first edge, mode 0 active.
REQ-037 Parameter sweep BARS=1, BARS=4 with H_ACTIVE=64 -> BARS=1 all blue; BARS=4 16-pixel bars blue, white, red, green.
